// File: rtl/teclado_clave.sv
// ---------------------------------------------------------------------------
// teclado_clave
//
// Keypad front-end for the gate access controller. Collects four BCD digit
// keystrokes into a 16-bit PIN (first digit in [15:12]), handles the clear
// and enter keys, discards a partial entry after an inter-key timeout, and
// presents the assembled code for exactly one cycle. Outside that cycle the
// code output carries CLAVE_REPOSO, which is not valid BCD and so never
// matches a PIN. Submitted attempts are counted, saturating at three.
//
// Ports:
//   clk             in   clock, all logic on posedge
//   reset           in   synchronous, active-high reset
//   habilitado      in   level, high while the controller waits for a PIN
//   tecla_valida    in   one-cycle strobe, tecla carries a digit key
//   tecla [3:0]     in   digit value, legal range 0..9
//   tecla_enter     in   one-cycle strobe, submit key
//   tecla_borrar    in   one-cycle strobe, clear key
//   clave_ingresada out  submitted BCD code during the ENVIO cycle, else CLAVE_REPOSO
//   clave_lista     out  one-cycle pulse, high exactly while a code is presented
//   digitos [2:0]   out  digits currently buffered, 0..4
//   error_tecla     out  one-cycle pulse on a rejected keystroke
//   timeout         out  one-cycle pulse when a partial entry expires
//   tercer_intento  out  level, high while the attempt counter equals 3
//   estado_dbg[1:0] out  current FSM state (0 INACTIVO, 1 CAPTURA, 2 ENVIO)
//
// Key interface: the three key inputs are single-cycle strobes with no
// back-pressure. A strobe is consumed on the rising edge where it is high;
// there is no ready signal, so keys that arrive in a state or cycle where
// they cannot be used are dropped (with error_tecla only where noted).
// ---------------------------------------------------------------------------
module teclado_clave #(
  parameter int unsigned TIMEOUT_CICLOS = 1000,
  parameter logic [15:0] CLAVE_REPOSO   = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        habilitado,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  input  logic        tecla_enter,
  input  logic        tecla_borrar,
  output logic [15:0] clave_ingresada,
  output logic        clave_lista,
  output logic [2:0]  digitos,
  output logic        error_tecla,
  output logic        timeout,
  output logic        tercer_intento,
  output logic [1:0]  estado_dbg
);

  // Timer counts 0..TIMEOUT_CICLOS-1, so clog2 of the count is enough bits.
  localparam int unsigned TW = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CICLOS - 1);

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CAPTURA  = 2'd1,
    ENVIO    = 2'd2
  } estado_t;

  estado_t        estado_q;
  logic [15:0]    buffer_q;
  logic [2:0]     digitos_q;
  logic [TW-1:0]  timer_q;
  logic [1:0]     intentos_q;
  logic [15:0]    clave_q;
  logic           lista_q;
  logic           error_q;
  logic           timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= INACTIVO;
      buffer_q   <= '0;
      digitos_q  <= '0;
      timer_q    <= '0;
      intentos_q <= '0;
      clave_q    <= CLAVE_REPOSO;
      lista_q    <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // Pulses and the presented code default back to idle every cycle so
      // each one is high for a single cycle per event.
      clave_q   <= CLAVE_REPOSO;
      lista_q   <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;

      case (estado_q)
        INACTIVO: begin
          // A new habilitado period starts a fresh vehicle: attempts restart.
          if (habilitado) begin
            estado_q   <= CAPTURA;
            buffer_q   <= '0;
            digitos_q  <= '0;
            timer_q    <= '0;
            intentos_q <= '0;
          end
        end

        CAPTURA: begin
          if (!habilitado) begin
            // Silent abandon; the attempt count survives until re-enable.
            estado_q  <= INACTIVO;
            buffer_q  <= '0;
            digitos_q <= '0;
            timer_q   <= '0;
          end else if (tecla_borrar) begin
            buffer_q  <= '0;
            digitos_q <= '0;
            timer_q   <= '0;
          end else if (tecla_enter) begin
            if (digitos_q == 3'd4) begin
              estado_q <= ENVIO;
              clave_q  <= buffer_q;
              lista_q  <= 1'b1;
            end else begin
              // Short entry is rejected outright and not counted.
              error_q   <= 1'b1;
              buffer_q  <= '0;
              digitos_q <= '0;
              timer_q   <= '0;
            end
          end else if (tecla_valida && (tecla <= 4'd9) && (digitos_q < 3'd4)) begin
            buffer_q  <= {buffer_q[11:0], tecla};
            digitos_q <= digitos_q + 3'd1;
            timer_q   <= '0;
          end else begin
            // No key accepted this cycle: a digit strobe reaching here was
            // either non-BCD or a fifth digit, and the timer keeps running.
            if (tecla_valida) begin
              error_q <= 1'b1;
            end
            if (digitos_q == 3'd0) begin
              timer_q <= '0;
            end else if (timer_q == TIMER_MAX) begin
              buffer_q  <= '0;
              digitos_q <= '0;
              timer_q   <= '0;
              timeout_q <= 1'b1;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end
        end

        ENVIO: begin
          // Single-cycle presentation; keys seen here are dropped silently.
          if (intentos_q != 2'd3) begin
            intentos_q <= intentos_q + 2'd1;
          end
          buffer_q  <= '0;
          digitos_q <= '0;
          timer_q   <= '0;
          estado_q  <= habilitado ? CAPTURA : INACTIVO;
        end

        default: begin
          estado_q <= INACTIVO;
        end
      endcase
    end
  end

  assign clave_ingresada = clave_q;
  assign clave_lista     = lista_q;
  assign digitos         = digitos_q;
  assign error_tecla     = error_q;
  assign timeout         = timeout_q;
  assign tercer_intento  = (intentos_q == 2'd3);
  assign estado_dbg      = estado_q;

endmodule

// File: tb/tb_teclado_clave.sv
// ---------------------------------------------------------------------------
// tb_teclado_clave
//
// Directed bench for teclado_clave with TIMEOUT_CICLOS = 8. Inputs change
// 1 ns after a rising edge; outputs are read at the same point, so every
// check sees the state produced by the edge that sampled the stimulus.
// ---------------------------------------------------------------------------
module tb_teclado_clave;

  localparam int unsigned T_CICLOS = 8;
  localparam logic [15:0] REPOSO   = 16'hFFFF;

  logic        clk;
  logic        reset;
  logic        habilitado;
  logic        tecla_valida;
  logic [3:0]  tecla;
  logic        tecla_enter;
  logic        tecla_borrar;
  logic [15:0] clave_ingresada;
  logic        clave_lista;
  logic [2:0]  digitos;
  logic        error_tecla;
  logic        timeout;
  logic        tercer_intento;
  logic [1:0]  estado_dbg;

  int n_cmp = 0;
  int n_err = 0;

  teclado_clave #(
    .TIMEOUT_CICLOS(T_CICLOS),
    .CLAVE_REPOSO  (REPOSO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .habilitado     (habilitado),
    .tecla_valida   (tecla_valida),
    .tecla          (tecla),
    .tecla_enter    (tecla_enter),
    .tecla_borrar   (tecla_borrar),
    .clave_ingresada(clave_ingresada),
    .clave_lista    (clave_lista),
    .digitos        (digitos),
    .error_tecla    (error_tecla),
    .timeout        (timeout),
    .tercer_intento (tercer_intento),
    .estado_dbg     (estado_dbg)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    tecla_valida = 1'b1;
    tecla        = d;
    tick();
    tecla_valida = 1'b0;
    tecla        = 4'd0;
  endtask

  task automatic press_enter();
    tecla_enter = 1'b1;
    tick();
    tecla_enter = 1'b0;
  endtask

  // Leaves time just after the enter edge, i.e. during the ENVIO cycle.
  task automatic submit4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
    press_digit(a);
    press_digit(b);
    press_digit(c);
    press_digit(d);
    press_enter();
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1; habilitado = 1'b0; tecla_valida = 1'b0; tecla = 4'd0;
    tecla_enter = 1'b0; tecla_borrar = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (clave_ingresada !== REPOSO) begin n_err++; $display("FAIL reset_clave: got %h want %h", clave_ingresada, REPOSO); end
    n_cmp++; if (clave_lista !== 1'b0) begin n_err++; $display("FAIL reset_lista: got %b want 0", clave_lista); end
    n_cmp++; if (digitos !== 3'd0) begin n_err++; $display("FAIL reset_digitos: got %0d want 0", digitos); end
    n_cmp++; if (error_tecla !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b want 0", error_tecla); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_cmp++; if (tercer_intento !== 1'b0) begin n_err++; $display("FAIL reset_tercer: got %b want 0", tercer_intento); end
    n_cmp++; if (estado_dbg !== 2'd0) begin n_err++; $display("FAIL reset_estado: got %0d want 0", estado_dbg); end
    // Keys while INACTIVO are ignored without an error pulse.
    press_digit(4'd5);
    n_cmp++; if ({digitos, error_tecla} !== 4'b0000) begin n_err++; $display("FAIL inactivo_ignore: got digitos=%0d err=%b want 0/0", digitos, error_tecla); end
    habilitado = 1'b1;
    tick();
    n_cmp++; if (estado_dbg !== 2'd1) begin n_err++; $display("FAIL enable_captura: got %0d want 1", estado_dbg); end
  endtask

  task automatic test_submit();
    press_digit(4'd1); press_digit(4'd1); press_digit(4'd9); press_digit(4'd4);
    n_cmp++; if (digitos !== 3'd4) begin n_err++; $display("FAIL submit_digitos4: got %0d want 4", digitos); end
    n_cmp++; if (clave_ingresada !== REPOSO) begin n_err++; $display("FAIL submit_preenter: got %h want %h", clave_ingresada, REPOSO); end
    press_enter();
    n_cmp++; if (clave_ingresada !== 16'h1194) begin n_err++; $display("FAIL submit_clave: got %h want 1194", clave_ingresada); end
    n_cmp++; if (clave_lista !== 1'b1) begin n_err++; $display("FAIL submit_lista: got %b want 1", clave_lista); end
    n_cmp++; if (estado_dbg !== 2'd2) begin n_err++; $display("FAIL submit_envio: got %0d want 2", estado_dbg); end
    tick();
    n_cmp++; if (clave_ingresada !== REPOSO) begin n_err++; $display("FAIL submit_idle: got %h want %h", clave_ingresada, REPOSO); end
    n_cmp++; if (clave_lista !== 1'b0) begin n_err++; $display("FAIL submit_lista_once: got %b want 0", clave_lista); end
    n_cmp++; if (digitos !== 3'd0) begin n_err++; $display("FAIL submit_digitos0: got %0d want 0", digitos); end
    n_cmp++; if (estado_dbg !== 2'd1) begin n_err++; $display("FAIL submit_back_captura: got %0d want 1", estado_dbg); end
  endtask

  task automatic test_short_enter();
    press_digit(4'd1); press_digit(4'd2);
    press_enter();
    n_cmp++; if (error_tecla !== 1'b1) begin n_err++; $display("FAIL short_error: got %b want 1", error_tecla); end
    n_cmp++; if (digitos !== 3'd0) begin n_err++; $display("FAIL short_digitos: got %0d want 0", digitos); end
    n_cmp++; if ({clave_lista, clave_ingresada} !== {1'b0, REPOSO}) begin n_err++; $display("FAIL short_noclave: got lista=%b clave=%h want 0/%h", clave_lista, clave_ingresada, REPOSO); end
    tick();
    n_cmp++; if (error_tecla !== 1'b0) begin n_err++; $display("FAIL short_error_once: got %b want 0", error_tecla); end
  endtask

  task automatic test_overflow();
    press_digit(4'd5); press_digit(4'd6);
    press_digit(4'hA);
    n_cmp++; if (error_tecla !== 1'b1) begin n_err++; $display("FAIL nonbcd_error: got %b want 1", error_tecla); end
    n_cmp++; if (digitos !== 3'd2) begin n_err++; $display("FAIL nonbcd_digitos: got %0d want 2", digitos); end
    press_digit(4'd7);
    n_cmp++; if (error_tecla !== 1'b0) begin n_err++; $display("FAIL digit_no_error: got %b want 0", error_tecla); end
    press_digit(4'd8);
    press_digit(4'd9);
    n_cmp++; if (error_tecla !== 1'b1) begin n_err++; $display("FAIL fifth_error: got %b want 1", error_tecla); end
    n_cmp++; if (digitos !== 3'd4) begin n_err++; $display("FAIL fifth_digitos: got %0d want 4", digitos); end
    press_enter();
    n_cmp++; if (clave_ingresada !== 16'h5678) begin n_err++; $display("FAIL overflow_clave: got %h want 5678", clave_ingresada); end
    n_cmp++; if (tercer_intento !== 1'b0) begin n_err++; $display("FAIL overflow_tercer: got %b want 0", tercer_intento); end
    tick();
    // Two counted submissions so far; the short enter must not have counted.
    n_cmp++; if (tercer_intento !== 1'b0) begin n_err++; $display("FAIL intentos_two: got %b want 0", tercer_intento); end
    submit4(4'd0, 4'd0, 4'd0, 4'd0);
    tick();
    n_cmp++; if (tercer_intento !== 1'b1) begin n_err++; $display("FAIL intentos_three: got %b want 1", tercer_intento); end
  endtask

  task automatic test_timeout();
    logic saw_to;
    saw_to = 1'b0;
    press_digit(4'd3);
    for (int i = 0; i < int'(T_CICLOS) - 1; i++) begin
      tick();
      saw_to = saw_to | timeout;
    end
    n_cmp++; if ({saw_to, digitos} !== {1'b0, 3'd1}) begin n_err++; $display("FAIL timeout_early: got to=%b digitos=%0d want 0/1", saw_to, digitos); end
    tick();
    n_cmp++; if (timeout !== 1'b1) begin n_err++; $display("FAIL timeout_pulse: got %b want 1", timeout); end
    n_cmp++; if (digitos !== 3'd0) begin n_err++; $display("FAIL timeout_digitos: got %0d want 0", digitos); end
    tick();
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL timeout_once: got %b want 0", timeout); end
    // A key every 7 cycles keeps restarting the timer.
    saw_to = 1'b0;
    press_digit(4'd3);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < int'(T_CICLOS) - 2; i++) begin
        tick();
        saw_to = saw_to | timeout;
      end
      press_digit(4'd3);
      saw_to = saw_to | timeout;
    end
    for (int i = 0; i < int'(T_CICLOS) - 2; i++) begin
      tick();
      saw_to = saw_to | timeout;
    end
    n_cmp++; if (saw_to !== 1'b0) begin n_err++; $display("FAIL keepalive_timeout: got %b want 0", saw_to); end
    n_cmp++; if (digitos !== 3'd4) begin n_err++; $display("FAIL keepalive_digitos: got %0d want 4", digitos); end
    tecla_borrar = 1'b1; tick(); tecla_borrar = 1'b0;
    n_cmp++; if (digitos !== 3'd0) begin n_err++; $display("FAIL borrar_digitos: got %0d want 0", digitos); end
  endtask

  task automatic test_attempts();
    habilitado = 1'b0; tick();
    n_cmp++; if ({estado_dbg, tercer_intento} !== {2'd0, 1'b1}) begin n_err++; $display("FAIL drop_hold: got estado=%0d tercer=%b want 0/1", estado_dbg, tercer_intento); end
    habilitado = 1'b1; tick();
    n_cmp++; if (tercer_intento !== 1'b0) begin n_err++; $display("FAIL reenable_clear: got %b want 0", tercer_intento); end
    submit4(4'd0, 4'd0, 4'd0, 4'd0); tick();
    submit4(4'd0, 4'd0, 4'd0, 4'd0); tick();
    n_cmp++; if (tercer_intento !== 1'b0) begin n_err++; $display("FAIL attempts_two: got %b want 0", tercer_intento); end
    submit4(4'd0, 4'd0, 4'd0, 4'd0);
    n_cmp++; if ({clave_lista, clave_ingresada, tercer_intento} !== {1'b1, 16'h0000, 1'b0}) begin n_err++; $display("FAIL third_present: got lista=%b clave=%h tercer=%b want 1/0000/0", clave_lista, clave_ingresada, tercer_intento); end
    tick();
    n_cmp++; if (tercer_intento !== 1'b1) begin n_err++; $display("FAIL third_tercer: got %b want 1", tercer_intento); end
    submit4(4'd0, 4'd0, 4'd0, 4'd0); tick();
    n_cmp++; if (tercer_intento !== 1'b1) begin n_err++; $display("FAIL fourth_saturate: got %b want 1", tercer_intento); end
    habilitado = 1'b0; tick();
    habilitado = 1'b1; tick();
    n_cmp++; if (tercer_intento !== 1'b0) begin n_err++; $display("FAIL new_vehicle: got %b want 0", tercer_intento); end
  endtask

  task automatic test_envio_ignore();
    submit4(4'd2, 4'd4, 4'd6, 4'd8);
    n_cmp++; if (clave_ingresada !== 16'h2468) begin n_err++; $display("FAIL envio_clave: got %h want 2468", clave_ingresada); end
    press_digit(4'd7);
    n_cmp++; if ({digitos, error_tecla, clave_lista} !== 5'b00000) begin n_err++; $display("FAIL envio_ignore: got digitos=%0d err=%b lista=%b want 0/0/0", digitos, error_tecla, clave_lista); end
  endtask

  task automatic test_reset_mid();
    press_digit(4'd1); press_digit(4'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if ({estado_dbg, digitos} !== {2'd0, 3'd0}) begin n_err++; $display("FAIL midreset_state: got estado=%0d digitos=%0d want 0/0", estado_dbg, digitos); end
    n_cmp++; if ({clave_ingresada, clave_lista, error_tecla, timeout, tercer_intento} !== {REPOSO, 4'b0000}) begin n_err++; $display("FAIL midreset_outputs: got clave=%h lista=%b err=%b to=%b ter=%b", clave_ingresada, clave_lista, error_tecla, timeout, tercer_intento); end
    tick();
    n_cmp++; if (estado_dbg !== 2'd1) begin n_err++; $display("FAIL midreset_reenable: got %0d want 1", estado_dbg); end
  endtask

  task automatic test_borrar_priority();
    press_digit(4'd9); press_digit(4'd8); press_digit(4'd7); press_digit(4'd6);
    tecla_borrar = 1'b1; tecla_enter = 1'b1; tick();
    tecla_borrar = 1'b0; tecla_enter = 1'b0;
    n_cmp++; if ({clave_lista, clave_ingresada} !== {1'b0, REPOSO}) begin n_err++; $display("FAIL borrar_enter_noclave: got lista=%b clave=%h", clave_lista, clave_ingresada); end
    n_cmp++; if ({digitos, error_tecla, estado_dbg} !== {3'd0, 1'b0, 2'd1}) begin n_err++; $display("FAIL borrar_enter_state: got digitos=%0d err=%b estado=%0d want 0/0/1", digitos, error_tecla, estado_dbg); end
    tick();
    n_cmp++; if (clave_lista !== 1'b0) begin n_err++; $display("FAIL borrar_enter_late: got %b want 0", clave_lista); end
    // Buffer really cleared: a bare enter is now a short entry.
    press_enter();
    n_cmp++; if (error_tecla !== 1'b1) begin n_err++; $display("FAIL borrar_then_enter: got %b want 1", error_tecla); end
    // borrar beats a digit in the same cycle.
    press_digit(4'd1);
    tecla_borrar = 1'b1; tecla_valida = 1'b1; tecla = 4'd2; tick();
    tecla_borrar = 1'b0; tecla_valida = 1'b0; tecla = 4'd0;
    n_cmp++; if (digitos !== 3'd0) begin n_err++; $display("FAIL borrar_digit: got %0d want 0", digitos); end
  endtask

  initial begin
    reset = 1'b1; habilitado = 1'b0; tecla_valida = 1'b0; tecla = 4'd0;
    tecla_enter = 1'b0; tecla_borrar = 1'b0;
    test_reset();
    test_submit();
    test_short_enter();
    test_overflow();
    test_timeout();
    test_attempts();
    test_envio_ignore();
    test_reset_mid();
    test_borrar_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/teclado_clave.md
Name: teclado_clave

Overview:
Keypad front-end that builds the 16-bit access PIN consumed by the gate access controller. It collects four BCD digit keystrokes and handles enter/clear keys and an inter-key timeout. It presents the assembled code for exactly one cycle and otherwise drives a non-matching idle code. It also counts submitted attempts so the controller side can raise its attempt alarm.

Parameters:
TIMEOUT_CICLOS, 1000, cycles allowed between keystrokes before a partial entry is discarded (min 2)
CLAVE_REPOSO, 16'hFFFF, code driven on clave_ingresada when no code is being presented (not valid BCD, so it never matches a PIN)

Ports:
clk  input  1  clock, all logic on posedge
reset  input  1  synchronous, active-high reset
habilitado  input  1  level; high while the controller is waiting for a PIN
tecla_valida  input  1  one-cycle strobe; tecla carries a digit key
tecla  input  4  digit value; legal range 0..9
tecla_enter  input  1  one-cycle strobe, submit key
tecla_borrar  input  1  one-cycle strobe, clear key
clave_ingresada  output  16  assembled BCD code, first digit in [15:12]; CLAVE_REPOSO otherwise
clave_lista  output  1  one-cycle pulse, high exactly while clave_ingresada holds a submitted code
digitos  output  3  digits currently buffered, 0..4
error_tecla  output  1  one-cycle pulse on a rejected keystroke
timeout  output  1  one-cycle pulse when a partial entry expires
tercer_intento  output  1  level, high when intentos == 3

Behaviour:
- Clocking and reset: single clock clk; reset is synchronous and active-high. On reset: state INACTIVO, buffer 0, digitos 0, timer 0, intentos 0, clave_ingresada = CLAVE_REPOSO, clave_lista, error_tecla, timeout and tercer_intento all 0.
- Reset asserted mid-entry or during ENVIO discards everything on that edge.
- All outputs are registered except tercer_intento, which is decoded from the intentos register.
- States: INACTIVO, CAPTURA, ENVIO.
- INACTIVO:
  - All keys ignored; no error pulse.
  - habilitado=1 moves to CAPTURA and clears buffer, digitos, timer and intentos.
- CAPTURA:
  - habilitado=0 moves to INACTIVO, discarding the buffer without a pulse; intentos is held.
  - Key priority within one cycle: tecla_borrar > tecla_enter > tecla_valida. Lower-priority strobes in the same cycle are dropped silently.
  - borrar: buffer=0, digitos=0, timer=0.
  - Digit with tecla > 9: error_tecla pulse next cycle; buffer unchanged.
  - Digit with digitos < 4: buffer = {buffer[11:0], tecla}, digitos+1, timer=0.
  - Digit with digitos == 4: ignored, error_tecla pulse.
  - enter with digitos == 4: move to ENVIO.
  - enter with digitos < 4: error_tecla pulse, buffer=0, digitos=0; no attempt is counted.
- Timer (CAPTURA only):
  - Held at 0 while digitos == 0.
  - Otherwise increments each cycle with no accepted key.
  - At value TIMEOUT_CICLOS-1 the next edge clears buffer, digitos and timer and pulses timeout.
  - A key accepted in the same cycle has priority over expiry.
- ENVIO (lasts exactly one cycle):
  - The enter sampled at edge N makes clave_ingresada = buffer and clave_lista = 1 for the cycle after edge N only.
  - At the following edge clave_ingresada returns to CLAVE_REPOSO.
  - intentos increments, saturating at 3.
  - Buffer and digitos clear.
  - Next state is CAPTURA if habilitado=1, else INACTIVO.
  - Keys arriving during ENVIO are ignored with no error pulse.
- tercer_intento stays high until habilitado rises again (new vehicle) or reset.
- error_tecla and timeout are never high for more than one consecutive cycle per event.

Test Plan:
1. Reset, habilitado=1, digits 1,1,9,4, enter -> one cycle later clave_ingresada=16'h1194 with clave_lista=1 for exactly one cycle, then 16'hFFFF; digitos returns to 0.
2. Digits 1,2, enter -> error_tecla single pulse, digitos=0, clave_ingresada stays 16'hFFFF, intentos unchanged.
3. Digits 5,6,7,8,9 -> fifth key gives error_tecla; then enter presents 16'h5678. A key 4'hA at any point gives error_tecla with the buffer unchanged.
4. TIMEOUT_CICLOS=8: digit 3, then idle 8 cycles -> timeout pulse, digitos=0. Same sequence with a key every 7 cycles -> no timeout.
5. Three full submissions of 16'h0000 -> tercer_intento=1 after the third clave_lista. A fourth submission keeps it at 1. Drop habilitado and raise it again -> tercer_intento=0.
6. Mid-entry (two digits) assert reset one cycle -> all outputs at reset values, state INACTIVO. Same-cycle borrar+enter with 4 digits -> buffer cleared, no clave_lista.
